// File: rtl/cvxif_instr_pkg.sv
// cvxif_instr_pkg: opcode encoding and result-entry control fields shared by the coprocessor ALU slice
package cvxif_instr_pkg;
  localparam int unsigned LatencyMax = 4;
  typedef enum logic [3:0] {
    NOP        = 4'd0,
    ADD        = 4'd1,
    DOUBLE_RS1 = 4'd2,
    DOUBLE_RS2 = 4'd3,
    ADD_MULTI  = 4'd4,
    ADD_RS3_R  = 4'd5,
    MADD       = 4'd6,
    MSUB       = 4'd7,
    NMADD      = 4'd8,
    NMSUB      = 4'd9,
    ROR64H     = 4'd10,
    ROR64L     = 4'd11
  } opcode_t;
  typedef struct packed {
    logic       we;
    logic [4:0] rd;
  } result_entry_t;
endpackage

// File: rtl/copro_result_fifo.sv
// copro_result_fifo: first-word-fall-through result buffer
//   clk_i/rst_i  clock, async active-high reset
//   flush_i      drop all buffered entries (wins over push/pop)
//   push_i/data_i write side; pop_i read side
//   data_o/valid_o head entry and its presence; count_o occupancy
module copro_result_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             valid_o,
  output logic [CntW-1:0]  count_o
);
  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wptr, rptr;
  logic             push_ok, pop_ok;
  assign pop_ok  = pop_i && count_o != '0;
  // a push into a full buffer is legal when the head leaves on the same edge
  assign push_ok = push_i && (count_o != CntW'(Depth) || pop_ok);
  assign valid_o = count_o != '0;
  assign data_o  = mem[rptr];
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      wptr    <= '0;
      rptr    <= '0;
      count_o <= '0;
    end else if (flush_i) begin
      wptr    <= '0;
      rptr    <= '0;
      count_o <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok) rptr <= rptr + 1'b1;
      count_o <= count_o + CntW'(push_ok) - CntW'(pop_ok);
    end
  always_ff @(posedge clk_i)
    if (push_ok && !flush_i) mem[wptr] <= data_i;
endmodule

// File: rtl/copro_alu_pipe.sv
// copro_alu_pipe: fixed-latency coprocessor ALU with credit-based issue and in-order result FIFO
//   clk_i/rst_i   clock, async active-high reset
//   flush_i       discard everything in flight and buffered
//   valid_i/ready_o + registers_i/opcode_i/hartid_i/id_i/rd_i/imm_i  issue side
//   valid_o/ready_i + result_o/hartid_o/id_o/rd_o/we_o               result side
module copro_alu_pipe
  import cvxif_instr_pkg::*;
#(
  parameter int unsigned NrRgprPorts = 2,
  parameter int unsigned XLEN        = 32,
  parameter int unsigned Latency     = 2,
  parameter int unsigned Depth       = 4,
  parameter type         hartid_t    = logic,
  parameter type         id_t        = logic,
  parameter type         registers_t = logic
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  registers_t      registers_i,
  input  opcode_t         opcode_i,
  input  hartid_t         hartid_i,
  input  id_t             id_i,
  input  logic [4:0]      rd_i,
  input  logic [5:0]      imm_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] result_o,
  output hartid_t         hartid_o,
  output id_t             id_o,
  output logic [4:0]      rd_o,
  output logic            we_o
);
  localparam int unsigned CntW = $clog2(Depth + 1);
  typedef logic [2:0][XLEN-1:0] ops_t;
  typedef struct packed {
    logic [XLEN-1:0] result;
    result_entry_t   ctl;
  } alu_out_t;
  typedef struct packed {
    hartid_t         hartid;
    id_t             id;
    logic [XLEN-1:0] result;
    result_entry_t   ctl;
  } entry_t;
  function automatic alu_out_t alu(input opcode_t op, input logic [XLEN-1:0] rs1, rs2, rs3,
                                   input logic [5:0] imm, input logic [4:0] rd);
    logic [4*XLEN-1:0] rot;
    alu_out_t o;
    // rotating a doubled copy keeps every shift amount in range, including 0 and XLEN
    rot = {rs1, rs2, rs1, rs2} >> imm;
    o.result = '0;
    o.ctl.we = 1'b1;
    o.ctl.rd = rd;
    case (op)
      ADD, ADD_MULTI: o.result = rs1 + rs2;
      DOUBLE_RS1:     o.result = rs1 + rs1;
      DOUBLE_RS2:     o.result = rs2 + rs2;
      ADD_RS3_R: begin
        o.result = rs1 + rs2 + rs3;
        o.ctl.rd = 5'd10;
      end
      MADD:           o.result = rs1 + rs2 + rs3;
      MSUB:           o.result = rs1 - rs2 - rs3;
      NMADD:          o.result = ~(rs1 + rs2 + rs3);
      NMSUB:          o.result = ~(rs1 - rs2 - rs3);
      ROR64H:         o.result = rot[2*XLEN-1:XLEN];
      ROR64L:         o.result = rot[XLEN-1:0];
      default:        o.ctl = '0;
    endcase
    return o;
  endfunction
  ops_t            ops;
  logic [XLEN-1:0] rs3;
  alu_out_t        a0;
  entry_t          e0, fo;
  logic            accept, pop;
  logic [Latency-1:0] pv;
  entry_t          pd [Latency];
  logic [CntW-1:0] count;
  assign ops    = ops_t'(registers_i);
  assign rs3    = NrRgprPorts == 3 ? ops[2] : '0;
  assign a0     = alu(opcode_i, ops[0], ops[1], rs3, imm_i, rd_i);
  assign e0     = '{hartid: hartid_i, id: id_i, result: a0.result, ctl: a0.ctl};
  // every accepted op holds a credit until popped, so the FIFO can never overflow
  assign ready_o = $countones(pv) + int'(count) < int'(Depth);
  assign accept  = valid_i && ready_o && !flush_i;
  assign pop     = valid_o && ready_i;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) pv <= '0;
    else if (flush_i) pv <= '0;
    else begin
      pv[0] <= accept;
      for (int i = 1; i < Latency; i++) pv[i] <= pv[i-1];
    end
  always_ff @(posedge clk_i) begin
    pd[0] <= e0;
    for (int i = 1; i < Latency; i++) pd[i] <= pd[i-1];
  end
  copro_result_fifo #(
    .Width($bits(entry_t)),
    .Depth(Depth)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .flush_i(flush_i),
    .push_i (pv[Latency-1]),
    .data_i (pd[Latency-1]),
    .pop_i  (pop),
    .data_o (fo),
    .valid_o(valid_o),
    .count_o(count)
  );
  // stale storage is never exposed: outputs read zero whenever nothing is presented
  assign result_o = valid_o ? fo.result : '0;
  assign hartid_o = valid_o ? fo.hartid : '0;
  assign id_o     = valid_o ? fo.id : '0;
  assign rd_o     = valid_o ? fo.ctl.rd : '0;
  assign we_o     = valid_o ? fo.ctl.we : 1'b0;
endmodule

// File: tb/tb_copro_alu_pipe.sv
// tb_copro_alu_pipe: directed scoreboard bench for copro_alu_pipe
module tb_copro_alu_pipe;
  import cvxif_instr_pkg::*;
  typedef logic [2:0][31:0] regs_t;
  typedef struct {
    logic [31:0] res;
    logic [1:0]  hart;
    logic [3:0]  id;
    logic [4:0]  rd;
    logic        we;
  } exp_t;
  logic        clk = 0, rst_i = 1, flush_i = 0, valid_i = 0, ready_i = 0;
  logic        ready_o, valid_o, we_o;
  regs_t       registers_i = '0;
  opcode_t     opcode_i = NOP;
  logic [1:0]  hartid_i = '0, hartid_o;
  logic [3:0]  id_i = '0, id_o;
  logic [4:0]  rd_i = '0, rd_o;
  logic [5:0]  imm_i = '0;
  logic [31:0] result_o;
  int          n_asrt = 0, n_fail = 0, next_id = 0;
  exp_t        sb[$];
  logic        acc;
  always #5 clk = ~clk;
  copro_alu_pipe #(
    .NrRgprPorts(3), .XLEN(32), .Latency(2), .Depth(4),
    .hartid_t(logic [1:0]), .id_t(logic [3:0]), .registers_t(regs_t)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
    .registers_i(registers_i), .opcode_i(opcode_i), .hartid_i(hartid_i), .id_i(id_i),
    .rd_i(rd_i), .imm_i(imm_i), .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o),
    .hartid_o(hartid_o), .id_o(id_o), .rd_o(rd_o), .we_o(we_o)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic exp_t model(input opcode_t op, input logic [31:0] a, b, c, input logic [5:0] imm,
                                 input logic [4:0] rd, input logic [1:0] h, input logic [3:0] id);
    logic [63:0] v, r;
    exp_t e;
    v = {a, b};
    r = (v >> imm) | (v << (7'd64 - {1'b0, imm}));
    e.hart = h; e.id = id; e.rd = rd; e.we = 1'b1; e.res = '0;
    case (op)
      ADD, ADD_MULTI: e.res = a + b;
      DOUBLE_RS1:     e.res = a + a;
      DOUBLE_RS2:     e.res = b + b;
      ADD_RS3_R:      begin e.res = a + b + c; e.rd = 5'd10; end
      MADD:           e.res = a + b + c;
      MSUB:           e.res = a - b - c;
      NMADD:          e.res = ~(a + b + c);
      NMSUB:          e.res = ~(a - b - c);
      ROR64H:         e.res = r[63:32];
      ROR64L:         e.res = r[31:0];
      default:        begin e.we = 1'b0; e.rd = '0; end
    endcase
    return e;
  endfunction
  task automatic issue(input opcode_t op, input logic [31:0] a, b, c, input logic [5:0] imm,
                       input logic [4:0] rd, output logic ok);
    id_i = 4'(next_id);
    hartid_i = 2'(next_id + 1);
    registers_i = {c, b, a};
    opcode_i = op; imm_i = imm; rd_i = rd; valid_i = 1'b1;
    @(negedge clk);
    ok = ready_o && !flush_i && !rst_i;
    if (ok) begin
      sb.push_back(model(op, a, b, c, imm, rd, hartid_i, id_i));
      next_id++;
    end
    @(posedge clk); #1 valid_i = 1'b0;
  endtask
  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    chk("drain_empty", 64'(sb.size()), 64'd0);
    @(posedge clk); #1;
  endtask
  always @(negedge clk)
    if (!rst_i && !flush_i && valid_o && ready_i) begin
      chk("sb_has_entry", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("pop", 64'({result_o, hartid_o, id_o, rd_o, we_o}), 64'({e.res, e.hart, e.id, e.rd, e.we}));
      end
    end
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    int n, cyc;
    logic seen;
    @(negedge clk);
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_outputs", 64'({result_o, hartid_o, id_o, rd_o, we_o}), 64'd0);
    @(posedge clk); #1 rst_i = 0;
    @(negedge clk);
    chk("ready_after_rst", 64'(ready_o), 64'd1);
    @(posedge clk); #1 ready_i = 1;
    issue(ADD, 32'd5, 32'd7, 32'd0, 6'd0, 5'd3, acc);
    chk("add_accept", 64'(acc), 64'd1);
    cyc = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (valid_o) break;
      cyc++;
    end
    chk("add_latency", 64'(cyc), 64'd2);
    chk("add_result", 64'({result_o, rd_o, we_o}), 64'({32'd12, 5'd3, 1'b1}));
    @(posedge clk); #1;
    issue(ROR64H, 32'h89ABCDEF, 32'h01234567, 32'd0, 6'd8, 5'd4, acc);
    issue(ROR64L, 32'h89ABCDEF, 32'h01234567, 32'd0, 6'd8, 5'd4, acc);
    issue(ROR64H, 32'h89ABCDEF, 32'h01234567, 32'd0, 6'd32, 5'd5, acc);
    issue(ROR64L, 32'h89ABCDEF, 32'h01234567, 32'd0, 6'd32, 5'd5, acc);
    issue(ROR64H, 32'h89ABCDEF, 32'h01234567, 32'd0, 6'd0, 5'd6, acc);
    issue(ROR64L, 32'h89ABCDEF, 32'h01234567, 32'd0, 6'd0, 5'd6, acc);
    issue(ROR64L, 32'h89ABCDEF, 32'h01234567, 32'd0, 6'd63, 5'd6, acc);
    issue(ADD, 32'hFFFFFFFF, 32'd1, 32'd0, 6'd0, 5'd7, acc);
    issue(ADD_MULTI, 32'd100, 32'd23, 32'd9, 6'd0, 5'd8, acc);
    issue(DOUBLE_RS1, 32'h80000003, 32'd1, 32'd0, 6'd0, 5'd9, acc);
    issue(DOUBLE_RS2, 32'd1, 32'd21, 32'd0, 6'd0, 5'd11, acc);
    issue(ADD_RS3_R, 32'd1, 32'd2, 32'd4, 6'd0, 5'd12, acc);
    issue(MADD, 32'd10, 32'd20, 32'd30, 6'd0, 5'd13, acc);
    issue(MSUB, 32'd10, 32'd20, 32'd30, 6'd0, 5'd14, acc);
    issue(NMADD, 32'd1, 32'd2, 32'd3, 6'd0, 5'd15, acc);
    issue(NMSUB, 32'd50, 32'd5, 32'd5, 6'd0, 5'd16, acc);
    issue(NOP, 32'd9, 32'd9, 32'd9, 6'd0, 5'd17, acc);
    issue(opcode_t'(4'd14), 32'd9, 32'd9, 32'd9, 6'd0, 5'd18, acc);
    drain();
    ready_i = 0;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      issue(ADD, 32'(i), 32'd100, 32'd0, 6'd0, 5'd1, acc);
      n += int'(acc);
    end
    chk("bp_accepts", 64'(n), 64'd4);
    @(negedge clk);
    chk("bp_ready_low", 64'(ready_o), 64'd0);
    chk("bp_valid_high", 64'(valid_o), 64'd1);
    @(posedge clk); #1 ready_i = 1;
    drain();
    ready_i = 0;
    for (int i = 0; i < 4; i++) issue(DOUBLE_RS2, 32'd0, 32'(i + 40), 32'd0, 6'd0, 5'd2, acc);
    repeat (3) @(posedge clk);
    #1 ready_i = 1;
    for (int i = 0; i < 8; i++) issue(ADD, 32'(i), 32'd1000, 32'd0, 6'd0, 5'd2, acc);
    drain();
    ready_i = 0;
    for (int i = 0; i < 3; i++) issue(ADD, 32'(i), 32'd7, 32'd0, 6'd0, 5'd3, acc);
    flush_i = 1;
    issue(ADD, 32'd3, 32'd3, 32'd0, 6'd0, 5'd3, acc);
    flush_i = 0;
    sb.delete();
    chk("flush_blocks_issue", 64'(acc), 64'd0);
    @(negedge clk);
    chk("ready_after_flush", 64'(ready_o), 64'd1);
    @(posedge clk); #1 ready_i = 1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      seen |= valid_o;
    end
    chk("no_valid_after_flush", 64'(seen), 64'd0);
    @(posedge clk); #1;
    issue(ADD, 32'd1, 32'd1, 32'd0, 6'd0, 5'd4, acc);
    drain();
    ready_i = 0;
    for (int i = 0; i < 3; i++) issue(MADD, 32'(i), 32'd5, 32'd6, 6'd0, 5'd5, acc);
    repeat (3) @(posedge clk);
    #1 chk("pre_rst_valid", 64'(valid_o), 64'd1);
    rst_i = 1;
    #1 chk("rst_async_outputs", 64'({valid_o, result_o, hartid_o, id_o, rd_o, we_o}), 64'd0);
    sb.delete();
    @(posedge clk); #1 rst_i = 0;
    ready_i = 1;
    @(negedge clk);
    chk("ready_after_midrst", 64'(ready_o), 64'd1);
    chk("valid_after_midrst", 64'(valid_o), 64'd0);
    @(posedge clk); #1;
    issue(ADD, 32'd20, 32'd22, 32'd0, 6'd0, 5'd6, acc);
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule

// File: doc/copro_alu_pipe.md
COPRO_ALU_PIPE -- requirements
Module: copro_alu_pipe

Interface
REQ-001 SHALL have parameter NrRgprPorts, default 2: number of source operands used (2 or 3).
REQ-002 SHALL have parameter XLEN, default 32: operand and result width.
REQ-003 SHALL have parameter Latency, default 2: pipeline stages from issue to result, range 1..4.
REQ-004 SHALL have parameter Depth, default 4: result FIFO entries, power of two, at least 2.
REQ-005 SHALL have parameters hartid_t, id_t and registers_t, default logic: transaction types.
REQ-006 SHALL have port clk_i  in  1: single clock, rising edge.
REQ-007 SHALL have port rst_i  in  1: reset, asynchronous and active-high.
REQ-008 SHALL have port flush_i  in  1: synchronous discard of all in-flight and buffered results.
REQ-009 SHALL have port valid_i  in  1: issue request.
REQ-010 SHALL have port ready_o  out  1: issue accept.
REQ-011 SHALL have the issue ports registers_i (registers_t), opcode_i (opcode_t), hartid_i, id_i, rd_i (5 bits) and imm_i (6 bits), all inputs: operands and tags.
REQ-012 SHALL have port valid_o  out  1: result available.
REQ-013 SHALL have port ready_i  in  1: result consumed.
REQ-014 SHALL have the result outputs result_o (XLEN bits), hartid_o, id_o, rd_o (5 bits) and we_o (1 bit).

Function
REQ-015 An issue SHALL be accepted on a rising edge where valid_i, ready_o and !flush_i are all high.
REQ-016 ready_o SHALL equal (in_flight + fifo_count < Depth), so an accepted result can never be dropped.
REQ-017 Results SHALL reach the FIFO Latency edges after acceptance, through a valid-tagged shift pipeline of Latency stages.
REQ-018 The FIFO SHALL be first-word-fall-through, so an idle unit presents valid_o Latency cycles after the accept edge.
REQ-019 A result SHALL pop on an edge where valid_o and ready_i are both high.
REQ-020 Results SHALL be delivered strictly in issue order.
REQ-021 A simultaneous push and pop with the FIFO full SHALL be legal: count unchanged, no loss.
REQ-022 A simultaneous push and pop with the FIFO empty SHALL pass through with no bubble.
REQ-023 FIFO pointers SHALL wrap modulo Depth.
REQ-024 ADD, ADD_MULTI: rs1+rs2. DOUBLE_RS1: rs1+rs1. DOUBLE_RS2: rs2+rs2. All arithmetic SHALL be modulo 2^XLEN.
REQ-025 MADD, MSUB, NMADD, NMSUB: rs1±rs2±rs3, and the N variants bitwise inverted; rs3 SHALL be omitted when NrRgprPorts=2.
REQ-026 ADD_RS3_R SHALL sum all operands and write rd=10.
REQ-027 ROR64H and ROR64L SHALL rotate the 64-bit value {rs1,rs2} right by imm_i (0..63) and return the high or low word respectively.
REQ-028 The rotate SHALL be exact at imm 0 (identity) and imm 32 (word swap), with no out-of-range shifts.
REQ-029 NOP SHALL return result 0, we_o=0, rd_o=0 and still produce a result entry.
REQ-030 Unknown opcodes SHALL return result 0, we_o=0 and the issued id, and SHALL still produce a result entry.
REQ-031 Every entry SHALL carry the hartid and id captured at accept.
REQ-032 flush_i SHALL clear all pipeline valid bits and the FIFO count on the next edge.
REQ-033 flush_i SHALL take priority over a simultaneous accept or pop.
REQ-034 ready_o SHALL be high in the cycle after a flush.

Reset
REQ-035 While rst_i is high, valid_o, ready_o-internal credit, pipeline valids, FIFO pointers and count SHALL all be 0.
REQ-036 While rst_i is high, result_o, hartid_o, id_o, rd_o and we_o SHALL all be 0.
REQ-037 Reset SHALL act asynchronously and release synchronously.
REQ-038 Reset mid-transaction SHALL discard all results.
REQ-039 ready_o SHALL be 1 from the first cycle after release.

Structure
REQ-040 opcode_t, including ROR64H and ROR64L, SHALL remain in cvxif_instr_pkg.
REQ-041 The result-entry struct and the LatencyMax=4 constant SHALL also be placed in cvxif_instr_pkg.
REQ-042 The FIFO SHALL be a sub-module, copro_result_fifo (parametrised width and depth, count output).
REQ-043 The operation decode SHALL be a combinational function in stage 0.

Verification
REQ-044 ADD rs1=5, rs2=7, rd=3, ready_i=1 -> valid_o after Latency cycles with result 12, rd 3, we 1.
REQ-045 ROR64H/ROR64L rs1=0x89ABCDEF, rs2=0x01234567, imm=8 -> 0x6789ABCD / 0xEF012345; imm=32 -> 0x01234567 / 0x89ABCDEF; imm=0 -> 0x89ABCDEF / 0x01234567.
REQ-046 ready_i=0 with back-to-back issues -> exactly Depth accepted, ready_o then 0; release ready_i -> all Depth results in order, ids intact.
REQ-047 Full FIFO with issue and pop in the same cycle -> no loss, count steady, order preserved.
REQ-048 flush_i asserted with 3 in flight plus an issue -> no valid_o afterwards, ready_o=1 next cycle, the next ADD 1+1 returns 2.
REQ-049 rst_i pulsed mid-stream -> all outputs 0 immediately; normal operation resumes after release.
